// File: rtl/cpu_mmu_csr_ctl_if.sv
// ---------------------------------------------------------------------------
// cpu_mmu_csr_ctl_if
// Bus bundle for the cache control/status register block.
//   CSR side   : csr_rd, csr_wr, wdata (toward block), idb_out (from block)
//   Tag RAM side: inv_req, inv_addr (from block), inv_ack (toward block)
// Modports:
//   slave  - view taken by cpu_mmu_csr_ctl
//   master - view taken by the surrounding microcode / tag RAM (or a bench)
// ---------------------------------------------------------------------------
interface cpu_mmu_csr_ctl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
);
   logic              csr_rd;
   logic              csr_wr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] idb_out;
   logic              inv_req;
   logic [ADDR_W-1:0] inv_addr;
   logic              inv_ack;

   modport slave (
      input  csr_rd, csr_wr, wdata, inv_ack,
      output idb_out, inv_req, inv_addr
   );

   modport master (
      output csr_rd, csr_wr, wdata, inv_ack,
      input  idb_out, inv_req, inv_addr
   );
endinterface

// File: rtl/cpu_mmu_csr_ctl.sv
// ---------------------------------------------------------------------------
// cpu_mmu_csr_ctl
// Cache control/status register. Holds the cache enable (con) and cache-up
// (cup) state, walks the tag RAM invalidate port through a full flush before
// the cache is declared up, and collects N_STAT sticky status events with
// write-1-to-clear semantics. All state is presented on the IDB while csr_rd
// is high.
// Ports:
//   sysclk    - system clock, all state changes on the rising edge
//   sys_rst   - synchronous active-high reset
//   stat_in   - raw status events, sampled every cycle
//   bus       - CSR strobes/data and tag RAM invalidate handshake
//   con       - cache enable latched
//   cup       - cache up (enabled and flush complete)
//   flushing  - flush in progress
//   irq       - level interrupt, OR of masked sticky bits
// Read word : [0] cup, [1] con, [2] ~con, [3] 1, [4+:N_STAT] sticky,
//             [DATA_W-1] flushing. DATA_W must be >= N_STAT+5.
// Write word: [0] ENABLE, [1] DISABLE (wins over ENABLE), [2] FLUSH,
//             [4+:N_STAT] write-1-to-clear sticky.
// ---------------------------------------------------------------------------
module cpu_mmu_csr_ctl #(
   parameter int                DATA_W      = 16,
   parameter int                N_STAT      = 4,
   parameter int                FLUSH_DEPTH = 1024,
   parameter logic [N_STAT-1:0] IRQ_MASK    = '1
) (
   input  logic              sysclk,
   input  logic              sys_rst,
   input  logic [N_STAT-1:0] stat_in,
   cpu_mmu_csr_ctl_if.slave  bus,
   output logic              con,
   output logic              cup,
   output logic              flushing,
   output logic              irq
);
   localparam int                ADDR_W   = $clog2(FLUSH_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FLUSH_DEPTH - 1);

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_ON    = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              want_q, want_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [N_STAT-1:0] sticky_q, sticky_d;
   logic              flushing_q, cup_q, irq_q;

   logic              wr_enable, wr_disable, wr_flush;
   logic [N_STAT-1:0] clr_mask;
   logic [DATA_W-1:0] rd_word;
   logic              unused_wdata;

   // DISABLE dominates: an ENABLE in the same write is dropped entirely.
   assign wr_disable = bus.csr_wr & bus.wdata[1];
   assign wr_enable  = bus.csr_wr & bus.wdata[0] & ~bus.wdata[1];
   assign wr_flush   = bus.csr_wr & bus.wdata[2];
   assign clr_mask   = bus.csr_wr ? bus.wdata[4 +: N_STAT] : '0;

   assign unused_wdata = ^{bus.wdata[DATA_W-1:4+N_STAT], bus.wdata[3]};

   always_comb begin
      // NOTE: every next-state signal gets a default first, so no branch can
      // leave one unassigned and infer a latch.
      state_d  = state_q;
      want_d   = want_q;
      cnt_d    = cnt_q;
      // A new event in the same cycle as its clear keeps the bit set.
      sticky_d = (sticky_q & ~clr_mask) | stat_in;

      case (state_q)
         ST_OFF: begin
            if (wr_enable) begin
               want_d  = 1'b1;
               state_d = ST_FLUSH;
            end else if (wr_flush) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            // Enable/disable during a flush only steer where the flush lands;
            // a further FLUSH request does not restart the walk.
            if (wr_enable)  want_d = 1'b1;
            if (wr_disable) want_d = 1'b0;
            if (bus.inv_ack) begin
               // FLUSH_DEPTH is a power of two, so the last increment wraps
               // the counter back to 0 and nothing of the walk is kept.
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_IDX) state_d = want_d ? ST_ON : ST_OFF;
            end
         end
         ST_ON: begin
            if (wr_disable) begin
               want_d  = 1'b0;
               state_d = wr_flush ? ST_FLUSH : ST_OFF;
            end else if (wr_flush) begin
               state_d = ST_FLUSH;
            end
         end
         default: begin
            state_d = ST_OFF;
            want_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples the pre-edge values regardless of statement order.
   always_ff @(posedge sysclk) begin
      if (sys_rst) begin
         state_q    <= ST_OFF;
         want_q     <= 1'b0;
         cnt_q      <= '0;
         sticky_q   <= '0;
         flushing_q <= 1'b0;
         cup_q      <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         want_q     <= want_d;
         cnt_q      <= cnt_d;
         sticky_q   <= sticky_d;
         flushing_q <= (state_d == ST_FLUSH);
         cup_q      <= (state_d == ST_ON);
         irq_q      <= |(sticky_d & IRQ_MASK);
      end
   end

   always_comb begin
      rd_word                = '0;
      rd_word[0]             = cup_q;
      rd_word[1]             = want_q;
      rd_word[2]             = ~want_q;
      rd_word[3]             = 1'b1;
      rd_word[4 +: N_STAT]   = sticky_q;
      rd_word[DATA_W-1]      = flushing_q;
   end

   assign bus.idb_out  = bus.csr_rd ? rd_word : '0;
   assign bus.inv_req  = flushing_q;
   assign bus.inv_addr = cnt_q;

   assign con      = want_q;
   assign cup      = cup_q;
   assign flushing = flushing_q;
   assign irq      = irq_q;
endmodule

// File: tb/tb_cpu_mmu_csr_ctl.sv
// ---------------------------------------------------------------------------
// tb_cpu_mmu_csr_ctl
// Bench for cpu_mmu_csr_ctl (FLUSH_DEPTH = 8). A reference model tracks the
// cache mode, the enable flag, the flush position and the sticky bits from
// the register rules; every cycle all outputs are compared against it, with
// directed scenarios followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_cpu_mmu_csr_ctl;
   localparam int                DATA_W      = 16;
   localparam int                N_STAT      = 4;
   localparam int                FLUSH_DEPTH = 8;
   localparam int                ADDR_W      = $clog2(FLUSH_DEPTH);
   localparam logic [N_STAT-1:0] IRQ_MASK    = 4'b0111;

   logic              sysclk = 1'b0;
   logic              sys_rst;
   logic [N_STAT-1:0] stat_in;
   logic              con, cup, flushing, irq;

   cpu_mmu_csr_ctl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   cpu_mmu_csr_ctl #(
      .DATA_W      (DATA_W),
      .N_STAT      (N_STAT),
      .FLUSH_DEPTH (FLUSH_DEPTH),
      .IRQ_MASK    (IRQ_MASK)
   ) dut (
      .sysclk   (sysclk),
      .sys_rst  (sys_rst),
      .stat_in  (stat_in),
      .bus      (bus),
      .con      (con),
      .cup      (cup),
      .flushing (flushing),
      .irq      (irq)
   );

   always #5 sysclk = ~sysclk;

   int    n_checks = 0;
   int    n_pass   = 0;
   string phase    = "init";

   // ---------------- reference model ----------------
   typedef enum int {M_OFF, M_FLUSH, M_ON} mode_t;
   mode_t             m_mode   = M_OFF;
   bit                m_on     = 1'b0;
   int                m_idx    = 0;
   bit [N_STAT-1:0]   m_sticky = '0;

   function automatic logic [DATA_W-1:0] m_word();
      int w;
      w = 8;
      if (m_mode == M_ON) w += 1;
      if (m_on) w += 2; else w += 4;
      w += int'(m_sticky) * 16;
      if (m_mode == M_FLUSH) w += 2 ** (DATA_W - 1);
      return DATA_W'(w);
   endfunction

   task automatic model_update();
      bit en, dis, fl;
      if (sys_rst) begin
         m_mode   = M_OFF;
         m_on     = 1'b0;
         m_idx    = 0;
         m_sticky = '0;
         return;
      end
      for (int i = 0; i < N_STAT; i++) begin
         if (stat_in[i]) m_sticky[i] = 1'b1;
         else if (bus.csr_wr && bus.wdata[4+i]) m_sticky[i] = 1'b0;
      end
      dis = bus.csr_wr && bus.wdata[1];
      en  = bus.csr_wr && bus.wdata[0] && !dis;
      fl  = bus.csr_wr && bus.wdata[2];
      case (m_mode)
         M_OFF: begin
            if (en) begin m_on = 1'b1; m_mode = M_FLUSH; end
            else if (fl) m_mode = M_FLUSH;
         end
         M_FLUSH: begin
            if (en)  m_on = 1'b1;
            if (dis) m_on = 1'b0;
            if (bus.inv_ack) begin
               if (m_idx == FLUSH_DEPTH - 1) begin
                  m_idx  = 0;
                  m_mode = m_on ? M_ON : M_OFF;
               end else begin
                  m_idx++;
               end
            end
         end
         default: begin
            if (dis) begin m_on = 1'b0; m_mode = fl ? M_FLUSH : M_OFF; end
            else if (fl) m_mode = M_FLUSH;
         end
      endcase
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic check_all();
      check({phase, ".inv_req"},  32'(bus.inv_req),  32'(m_mode == M_FLUSH));
      check({phase, ".inv_addr"}, 32'(bus.inv_addr), m_idx);
      check({phase, ".con"},      32'(con),          32'(m_on));
      check({phase, ".cup"},      32'(cup),          32'(m_mode == M_ON));
      check({phase, ".flushing"}, 32'(flushing),     32'(m_mode == M_FLUSH));
      check({phase, ".irq"},      32'(irq),          32'(|(m_sticky & IRQ_MASK)));
      check({phase, ".idb"},      32'(bus.idb_out),  32'(bus.csr_rd ? m_word() : '0));
   endtask

   // Inputs are set at the falling edge; the pre-edge read check covers the
   // same-cycle read-during-write case.
   task automatic step();
      #1;
      if (!sys_rst)
         check({phase, ".idb_pre"}, 32'(bus.idb_out), 32'(bus.csr_rd ? m_word() : '0));
      @(posedge sysclk);
      model_update();
      @(negedge sysclk);
      check_all();
   endtask

   task automatic wr(input logic [DATA_W-1:0] data);
      bus.csr_wr = 1'b1;
      bus.wdata  = data;
      step();
      bus.csr_wr = 1'b0;
      bus.wdata  = '0;
   endtask

   task automatic run_to_addr(input int n);
      int g = 0;
      while (int'(bus.inv_addr) != n && g < 4 * FLUSH_DEPTH) begin
         step();
         g++;
      end
      check({phase, ".reach_addr"}, 32'(bus.inv_addr), n);
   endtask

   task automatic drain();
      int g = 0;
      while (flushing && g < 4 * FLUSH_DEPTH) begin
         step();
         g++;
      end
      check({phase, ".drained"}, 32'(flushing), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      sys_rst     = 1'b1;
      stat_in     = '0;
      bus.csr_rd  = 1'b1;
      bus.csr_wr  = 1'b0;
      bus.wdata   = '0;
      bus.inv_ack = 1'b0;

      // Reset
      phase = "reset";
      step();
      step();
      check("rst.idb",     32'(bus.idb_out), 32'h000C);
      check("rst.inv_req", 32'(bus.inv_req), 0);
      check("rst.irq",     32'(irq),         0);
      sys_rst = 1'b0;

      // Enable with ack tied high: exactly FLUSH_DEPTH flushing cycles
      phase = "enable";
      bus.inv_ack = 1'b1;
      wr(16'h0001);
      for (int i = 0; i < FLUSH_DEPTH; i++) begin
         check("en.flushing", 32'(flushing),     1);
         check("en.inv_addr", 32'(bus.inv_addr), i);
         step();
      end
      check("en.cup",     32'(cup),         1);
      check("en.con",     32'(con),         1);
      check("en.inv_req", 32'(bus.inv_req), 0);
      check("en.idb",     32'(bus.idb_out), 32'h000B);

      // Ack stall at address 3
      phase = "stall";
      wr(16'h0004);
      run_to_addr(3);
      bus.inv_ack = 1'b0;
      repeat (5) begin
         step();
         check("stall.addr", 32'(bus.inv_addr), 3);
         check("stall.req",  32'(bus.inv_req),  1);
      end
      bus.inv_ack = 1'b1;
      step();
      check("stall.resume", 32'(bus.inv_addr), 4);
      drain();
      check("stall.cup", 32'(cup), 1);

      // Disable mid-flush: walk completes, lands OFF
      phase = "disable";
      wr(16'h0004);
      run_to_addr(2);
      wr(16'h0002);
      check("dis.con_now",  32'(con),      0);
      check("dis.flushing", 32'(flushing), 1);
      drain();
      check("dis.cup", 32'(cup),         0);
      check("dis.con", 32'(con),         0);
      check("dis.idb", 32'(bus.idb_out), 32'h000C);

      // Sticky status
      phase = "sticky";
      stat_in = 4'b0010;
      step();
      stat_in = '0;
      check("stk.bit5", 32'(bus.idb_out[5]), 1);
      check("stk.irq",  32'(irq),            1);
      step();
      check("stk.hold", 32'(bus.idb_out[5]), 1);
      stat_in     = 4'b0010;
      bus.csr_wr  = 1'b1;
      bus.wdata   = 16'h0020;
      step();
      bus.csr_wr  = 1'b0;
      bus.wdata   = '0;
      stat_in     = '0;
      check("stk.set_wins", 32'(bus.idb_out[5]), 1);
      wr(16'h0020);
      check("stk.cleared", 32'(bus.idb_out[5]), 0);
      check("stk.irq_off", 32'(irq),            0);
      stat_in = 4'b1000;
      step();
      stat_in = '0;
      check("stk.bit7",       32'(bus.idb_out[7]), 1);
      check("stk.masked_irq", 32'(irq),            0);
      wr(16'h0080);
      check("stk.bit7_clr", 32'(bus.idb_out[7]), 0);

      // Reset in the middle of a flush
      phase = "rstflush";
      wr(16'h0001);
      run_to_addr(5);
      sys_rst = 1'b1;
      step();
      sys_rst = 1'b0;
      check("rf.inv_req", 32'(bus.inv_req),  0);
      check("rf.addr",    32'(bus.inv_addr), 0);
      wr(16'h0001);
      check("rf.restart",  32'(bus.inv_addr), 0);
      check("rf.flushing", 32'(flushing),     1);
      drain();
      check("rf.cup", 32'(cup), 1);

      // Randomized traffic against the model
      phase = "rand";
      for (int i = 0; i < 400; i++) begin
         sys_rst     = ($urandom_range(63) == 0);
         stat_in     = ($urandom_range(3) == 0) ? N_STAT'($urandom) : '0;
         bus.csr_rd  = 1'($urandom_range(1));
         bus.csr_wr  = ($urandom_range(3) == 0);
         bus.wdata   = DATA_W'($urandom);
         bus.inv_ack = ($urandom_range(2) != 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
